// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, widths and the receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ = 100_000_000;
  localparam int unsigned UART_BAUD     = 115_200;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake from the UART receiver to a consuming FSM.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              framing_error;
  logic              overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output framing_error,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  framing_error,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Capture the async input, then let any metastability settle in the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/ready byte output and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_CLK_FREQ,
  parameter int unsigned BAUD     = UART_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(DATA_W - 1);

  logic rx_s;

  uart_rx_state          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  fe_q, fe_d;
  logic                  ovr_q, ovr_d;

  logic half_done;
  logic bit_done;
  logic accept;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign half_done = (cnt_q == HALF_LAST);
  assign bit_done  = (cnt_q == BIT_LAST);
  assign accept    = rx_valid_q && bus.rx_ready;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next-state: confirm start at half a bit, walk 8 data bits, leave from mid stop bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (half_done) state_d = rx_s ? IDLE : DATA;
      DATA:  if (bit_done && (idx_q == IDX_LAST)) state_d = STOP;
      STOP:  if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: bit timing, shifting, byte hand-off and error pulses.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !bus.rx_ready;
    fe_d       = 1'b0;
    ovr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      START: begin
        idx_d = '0;
        cnt_d = half_done ? '0 : cnt_q + CNT_W'(1);
      end
      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + BIT_IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (!rx_s) begin
            fe_d = 1'b1;
          end else if (!rx_valid_q || accept) begin
            // A same-edge accept frees the slot, so the new byte is not an overrun.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: latency, handshake, overrun, framing, glitch, reset, back-to-back.
module tb_uart_rx;

  // Bit period shortened by halving the clock; BAUD unchanged. 50e6/115200 -> 434 clks per bit.
  localparam int unsigned CLK_FREQ_TB = 50_000_000;
  localparam int unsigned BAUD_TB     = 115_200;
  localparam int          CPB         = 434;
  // 2 sync + CPB/2 (217) + 9*CPB (3906) = 4125
  localparam int          LAT         = 4125;
  localparam int          FRAME       = 10 * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (CLK_FREQ_TB),
    .BAUD     (BAUD_TB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc      = 0;
  int e0       = 0;
  int rise_n   = 0;
  int rise_cyc = -1;
  int fe_n     = 0;
  int fe_cyc   = -1;
  int ovr_n    = 0;
  int ovr_cyc  = -1;
  logic valid_prev = 1'b0;
  logic [7:0] acc_data[$];
  int         acc_cyc[$];

  // Event log: values seen here were launched by edge number cyc.
  always @(posedge clk) begin
    if (bus.framing_error) begin fe_n++; fe_cyc = cyc; end
    if (bus.overrun)       begin ovr_n++; ovr_cyc = cyc; end
    if (bus.rx_valid && !valid_prev) begin rise_n++; rise_cyc = cyc; end
    valid_prev = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) begin
      acc_data.push_back(bus.rx_data);
      acc_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame LSB first; caller is aligned to a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  int rise0, fe0, ovr0, acc0, e0_first;

  initial begin
    bus.rx_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(bus.rx_data), 32'h00);
    chk("rst_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_fe",    32'(bus.framing_error), 32'h0);
    chk("rst_ovr",   32'(bus.overrun), 32'h0);
    chk("rst_sync",  32'(dut.rx_s), 32'h1);
    chk("rst_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame 0x44, consumer always ready.
    bus.rx_ready = 1'b1;
    rise0 = rise_n; fe0 = fe_n; ovr0 = ovr_n; acc0 = acc_data.size();
    send_frame(8'h44, 1'b1);
    chk("f44_rise_n",   32'(rise_n - rise0), 32'd1);
    chk("f44_rise_cyc", 32'(rise_cyc), 32'(e0 + LAT));
    chk("f44_acc_n",    32'(acc_data.size() - acc0), 32'd1);
    chk("f44_data",     32'(acc_data[acc_data.size()-1]), 32'h44);
    chk("f44_acc_cyc",  32'(acc_cyc[acc_cyc.size()-1]), 32'(e0 + LAT));
    chk("f44_valid_low", 32'(bus.rx_valid), 32'h0);
    chk("f44_no_err",   32'((fe_n - fe0) + (ovr_n - ovr0)), 32'd0);
    repeat (50) @(negedge clk);

    // Two frames with consumer stalled: second one overruns.
    bus.rx_ready = 1'b0;
    ovr0 = ovr_n; acc0 = acc_data.size();
    send_frame(8'hA5, 1'b1);
    chk("a5_rise_cyc", 32'(rise_cyc), 32'(e0 + LAT));
    chk("a5_valid",    32'(bus.rx_valid), 32'h1);
    chk("a5_data",     32'(bus.rx_data), 32'hA5);
    chk("a5_no_ovr",   32'(ovr_n - ovr0), 32'd0);
    send_frame(8'h3C, 1'b1);
    chk("3c_ovr_n",    32'(ovr_n - ovr0), 32'd1);
    chk("3c_ovr_cyc",  32'(ovr_cyc), 32'(e0 + LAT));
    chk("3c_data_kept", 32'(bus.rx_data), 32'hA5);
    chk("3c_valid_kept", 32'(bus.rx_valid), 32'h1);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    chk("a5_accept_valid", 32'(bus.rx_valid), 32'h0);
    chk("a5_accept_n",     32'(acc_data.size() - acc0), 32'd1);
    chk("a5_accept_data",  32'(acc_data[acc_data.size()-1]), 32'hA5);
    repeat (50) @(negedge clk);

    // Bad stop bit, then a clean frame.
    bus.rx_ready = 1'b1;
    rise0 = rise_n; fe0 = fe_n;
    send_frame(8'h81, 1'b0);
    chk("81_fe_n",   32'(fe_n - fe0), 32'd1);
    chk("81_fe_cyc", 32'(fe_cyc), 32'(e0 + LAT));
    chk("81_no_rise", 32'(rise_n - rise0), 32'd0);
    chk("81_valid",  32'(bus.rx_valid), 32'h0);
    repeat (500) @(negedge clk);
    chk("81_fe_once", 32'(fe_n - fe0), 32'd1);
    send_frame(8'h12, 1'b1);
    chk("12_rise_cyc", 32'(rise_cyc), 32'(e0 + LAT));
    chk("12_data",     32'(acc_data[acc_data.size()-1]), 32'h12);
    repeat (50) @(negedge clk);

    // 200-clk low glitch is a false start.
    rise0 = rise_n; fe0 = fe_n; ovr0 = ovr_n;
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (250) @(negedge clk);
    chk("glitch_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    chk("glitch_no_rise", 32'(rise_n - rise0), 32'd0);
    chk("glitch_no_err", 32'((fe_n - fe0) + (ovr_n - ovr0)), 32'd0);
    repeat (CPB * 12) @(negedge clk);
    chk("glitch_late_no_rise", 32'(rise_n - rise0), 32'd0);

    // Reset in the middle of bit 4 of frame 0xF0.
    rise0 = rise_n;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("pre_rst_state", 32'(dut.state_q), 32'(uart_pkg::DATA));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_data",  32'(bus.rx_data), 32'h00);
    chk("mid_rst_valid", 32'(bus.rx_valid), 32'h0);
    chk("mid_rst_fe",    32'(bus.framing_error), 32'h0);
    chk("mid_rst_ovr",   32'(bus.overrun), 32'h0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (CPB * 6) @(negedge clk);
    chk("post_rst_no_rise", 32'(rise_n - rise0), 32'd0);
    send_frame(8'h55, 1'b1);
    chk("55_rise_cyc", 32'(rise_cyc), 32'(e0 + LAT));
    chk("55_data",     32'(acc_data[acc_data.size()-1]), 32'h55);
    repeat (50) @(negedge clk);

    // Back-to-back frames with no idle gap.
    acc0 = acc_data.size(); fe0 = fe_n; ovr0 = ovr_n;
    send_frame(8'h00, 1'b1);
    e0_first = e0;
    send_frame(8'hFF, 1'b1);
    send_frame(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    chk("b2b_n",     32'(acc_data.size() - acc0), 32'd3);
    chk("b2b_d0",    32'(acc_data[acc0]),     32'h00);
    chk("b2b_d1",    32'(acc_data[acc0 + 1]), 32'hFF);
    chk("b2b_d2",    32'(acc_data[acc0 + 2]), 32'h7E);
    chk("b2b_c0",    32'(acc_cyc[acc0]),     32'(e0_first + LAT));
    chk("b2b_gap01", 32'(acc_cyc[acc0 + 1] - acc_cyc[acc0]),     32'(FRAME));
    chk("b2b_gap12", 32'(acc_cyc[acc0 + 2] - acc_cyc[acc0 + 1]), 32'(FRAME));
    chk("b2b_no_err", 32'((fe_n - fe0) + (ovr_n - ovr0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It is the receive-direction counterpart of the byte transmitter that the motor-control state machines feed through tx_data/tx_valid/tx_ready. It converts the incoming serial line into bytes and presents them on a matching rx_data/rx_valid/rx_ready handshake, so command decoders can take bytes from the base station. It sits between the board RX pin and any command-consuming FSM.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, CLK_FREQ/BAUD (868), clocks per bit, derived, not overridden
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- rx  input  1  raw serial line, asynchronous to clk, idle 1
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready on a clk edge
- framing_error  output  1  one-cycle pulse: stop bit sampled 0, byte discarded
- overrun  output  1  one-cycle pulse: new byte completed while rx_valid still 1, new byte discarded

## Operation
- rx passes through a 2-flop synchronizer → rx_s; both flops reset to 1.
- Bit counter: 10 bits, counts 0..CLKS_PER_BIT-1. Bit index: 3 bits. Shift register: 8 bits, shifts right, new bit enters MSB.
- IDLE: counter held 0. On rx_s==0 → START.
- START: count to CLKS_PER_BIT/2-1 (433). At terminal count: rx_s==1 → false start, return to IDLE; rx_s==0 → DATA, counter 0, index 0.
- DATA: at counter==CLKS_PER_BIT-1, sample rx_s into shift register and increment index. After index 7 → STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s, then → IDLE in all cases (mid stop bit, so back-to-back frames are caught).
  - rx_s==1 and rx_valid==0: load rx_data, set rx_valid.
  - rx_s==1 and rx_valid==1 with no handshake this cycle: pulse overrun; rx_data and rx_valid are unchanged.
  - rx_s==0: pulse framing_error; no load.
- Handshake: rx_valid clears on the edge where rx_valid && rx_ready. If a load and an accept happen on the same edge, the new byte loads and rx_valid stays 1. This is not an overrun.
- rx_valid does not depend combinationally on rx_ready.

## Timing
- Reset values: rx_data=0x00, rx_valid=0, framing_error=0, overrun=0, state IDLE, counters 0, sync flops 1.
- Reset asserted mid-frame aborts it immediately. After release, a receive starts only on a new falling edge of rx_s.
- Latency: let E0 be the first edge at which rx is sampled 0 for a valid frame. rx_valid rises on edge E0+8248 (2 sync + 434 + 9×868).
- Sample points fall at bit centres ±1 clk. Tolerated baud mismatch is at least ±2%.
- Low glitches shorter than 434 clks (after sync) are rejected as false starts.
- framing_error and overrun are registered and asserted for exactly one clk.
- Throughput: continuous back-to-back frames at BAUD with rx_ready tied 1 lose no bytes.

## Structure
- Shared package uart_pkg holds:
  - the state enum uart_rx_state {IDLE, START, DATA, STOP}
  - the default CLK_FREQ and BAUD constants, shared with the transmitter
- One sub-module: sync_2ff, a 2-flop synchronizer with reset value parameter (1 here). It is reused for the sensor inputs.
- The rest is a single FSM plus datapath in uart_rx.

## Test plan
- Frame 0x44 at 115200, rx_ready=1 → rx_data=0x44 and rx_valid high for 1 clk at E0+8248; no error pulses.
- Frames 0xA5 then 0x3C, rx_ready=0 throughout → rx_data=0xA5 stays valid; overrun pulses once at the end of the second frame. Then rx_ready=1 for 1 clk → rx_valid=0.
- Frame 0x81 with stop bit driven 0 → framing_error pulses 1 clk at E0+8248; rx_valid stays 0; next good frame 0x12 is received correctly.
- rx low for 200 clks, then high → no rx_valid, no error; state back in IDLE before clk 450.
- reset asserted at bit 4 of frame 0xF0 → all outputs 0 within the same cycle. After release and line idle, frame 0x55 → rx_data=0x55.
- Back-to-back frames 0x00, 0xFF, 0x7E with no idle gap, rx_ready=1 → three rx_valid pulses with values in order, spaced 8680 clks.
